// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage (with package rv32imc_types)
//  Description : RV32 memory-access stage. Issues byte-lane data-memory
//                requests once per instruction and registers the result
//                for writeback.
//  Revision    : 1.0  initial release
// ============================================================================

package rv32imc_types;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
    } mem_ctrl_t;

    typedef struct packed {
        logic       regf_we;
        logic [1:0] wb_sel;
    } wb_ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [1:0]  mode;
        logic [1:0]  ixl;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } ex_stage_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        mem_ctrl_t   mem_ctrl;
        wb_ctrl_t    wb_ctrl;
        rvfi_t       rvfi;
    } mem_stage_t;

endpackage

module mem_stage
    import rv32imc_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_stall,
    input  ex_stage_t   ex_stage_reg,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    output logic        misaligned,
    output logic        fwd_regf_we,
    output logic [4:0]  fwd_rd_addr,
    output logic [31:0] fwd_data,
    output mem_stage_t  mem_stage_reg
);

    logic [1:0]  off;
    logic [2:0]  f3;
    logic        req_rd;
    logic        req_wr;

    logic [3:0]  ld_mask;
    logic        ld_mis;
    logic [3:0]  st_mask;
    logic        st_mis;
    logic [31:0] st_data;

    logic [3:0]  rmask_raw;
    logic [3:0]  wmask_raw;
    logic [31:0] wdata_raw;

    logic        issued_q;
    logic        issued_d;
    mem_stage_t  mem_stage_q;
    mem_stage_t  mem_stage_d;

    assign off    = ex_stage_reg.alu_out[1:0];
    assign f3     = ex_stage_reg.mem_ctrl.funct3;
    assign req_rd = ex_stage_reg.rvfi.valid & ex_stage_reg.mem_ctrl.mem_read;
    assign req_wr = ex_stage_reg.rvfi.valid & ex_stage_reg.mem_ctrl.mem_write;

    always_comb begin
        ld_mask = 4'b0000;
        ld_mis  = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ld_mask = 4'b0001 << off;
            F3_LH, F3_LHU: begin
                ld_mask = 4'b0011 << {off[1], 1'b0};
                ld_mis  = off[0];
            end
            F3_LW: begin
                ld_mask = 4'b1111;
                ld_mis  = (off != 2'b00);
            end
            default: ld_mask = 4'b0000;
        endcase

        st_mask = 4'b0000;
        st_mis  = 1'b0;
        st_data = 32'h0000_0000;
        case (f3)
            F3_SB: begin
                st_mask = 4'b0001 << off;
                st_data = {24'h00_0000, ex_stage_reg.rs2_rdata[7:0]} << {off, 3'b000};
            end
            F3_SH: begin
                st_mask = 4'b0011 << {off[1], 1'b0};
                st_mis  = off[0];
                st_data = {16'h0000, ex_stage_reg.rs2_rdata[15:0]} << {off[1], 4'b0000};
            end
            F3_SW: begin
                st_mask = 4'b1111;
                st_mis  = (off != 2'b00);
                st_data = ex_stage_reg.rs2_rdata;
            end
            default: st_mask = 4'b0000;
        endcase
    end

    // A misaligned access suppresses both lanes, even if only one side faults.
    assign misaligned = (req_rd & ld_mis) | (req_wr & st_mis);
    assign rmask_raw  = (req_rd && !misaligned) ? ld_mask : 4'b0000;
    assign wmask_raw  = (req_wr && !misaligned) ? st_mask : 4'b0000;
    assign wdata_raw  = (wmask_raw != 4'b0000) ? st_data : 32'h0000_0000;

    assign dmem_addr  = {ex_stage_reg.alu_out[31:2], 2'b00};
    assign dmem_rmask = issued_q ? 4'b0000 : rmask_raw;
    assign dmem_wmask = issued_q ? 4'b0000 : wmask_raw;
    assign dmem_wdata = wdata_raw;

    // Remember that a stalled instruction already issued so it is not replayed.
    always_comb begin
        issued_d = issued_q;
        if (!mem_stall) begin
            issued_d = 1'b0;
        end else if ((dmem_rmask | dmem_wmask) != 4'b0000) begin
            issued_d = 1'b1;
        end
    end

    always_comb begin
        mem_stage_d = mem_stage_q;
        if (!mem_stall) begin
            mem_stage_d.alu_out        = ex_stage_reg.alu_out;
            mem_stage_d.rs2_rdata      = ex_stage_reg.rs2_rdata;
            mem_stage_d.rd_addr        = ex_stage_reg.rd_addr;
            mem_stage_d.mem_ctrl       = ex_stage_reg.mem_ctrl;
            mem_stage_d.wb_ctrl        = ex_stage_reg.wb_ctrl;
            mem_stage_d.rvfi           = ex_stage_reg.rvfi;
            // Record the unsuppressed request so the trace is stable across stalls.
            mem_stage_d.rvfi.mem_addr  = dmem_addr;
            mem_stage_d.rvfi.mem_rmask = rmask_raw;
            mem_stage_d.rvfi.mem_wmask = wmask_raw;
            mem_stage_d.rvfi.mem_wdata = wdata_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q    <= 1'b0;
            mem_stage_q <= '0;
        end else begin
            issued_q    <= issued_d;
            mem_stage_q <= mem_stage_d;
        end
    end

    assign mem_stage_reg = mem_stage_q;
    assign fwd_regf_we   = mem_stage_q.wb_ctrl.regf_we & mem_stage_q.rvfi.valid;
    assign fwd_rd_addr   = mem_stage_q.rd_addr;
    assign fwd_data      = mem_stage_q.alu_out;

endmodule

`default_nettype wire
